// File: rtl/rng_roll_ctrl.sv
// rng_roll_ctrl: roll sequencer for the 4-bit random-number datapath.
// Each start pulse issues o_step pulses at intervals that grow by
// BASE_INTERVAL, so the displayed value slows down like a roulette.
// The roll ends after NUM_STEPS steps, or early on i_stop. The last
// sampled value is then held on o_display.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : pulse, starts or restarts a roll (wins over i_stop)
//   i_stop         : pulse, ends the current roll after one more step
//   i_rand         : current value of the random source
//   o_step         : one-cycle advance pulse to the random source
//   o_busy         : high while a roll is in progress
//   o_done         : one-cycle pulse when o_display is final
//   o_display      : last sampled random value
//   o_prev         : previous completed result
//
// Optional macro RNG_ROLL_HISTORY_EN keeps the previous result on
// o_prev. Without it o_prev is tied to zero.
module rng_roll_ctrl #(
    parameter int unsigned BASE_INTERVAL = 500_000,
    parameter int unsigned NUM_STEPS     = 16,
    parameter int unsigned TIMER_W       = 24
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [3:0] i_rand,
    output logic       o_step,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_display,
    output logic [3:0] o_prev
);

    localparam int unsigned CNT_W = $clog2(NUM_STEPS) + 1;

    localparam logic [TIMER_W-1:0] BASE =
        TIMER_W'(BASE_INTERVAL);
    localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
    localparam logic [CNT_W-1:0] LAST_STEP =
        CNT_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic               final_q, final_d;
    logic [3:0]         display_q, display_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        interval_d = interval_q;
        step_cnt_d = step_cnt_q;
        final_d    = final_q;
        display_d  = display_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_WAIT;
                    timer_d    = '0;
                    interval_d = BASE;
                    step_cnt_d = '0;
                    final_d    = 1'b0;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + T_ONE;
                if (i_start) begin
                    // Restart: same loads as a fresh start.
                    timer_d    = '0;
                    interval_d = BASE;
                    step_cnt_d = '0;
                    final_d    = 1'b0;
                end else if (i_stop) begin
                    // One last step, then finish.
                    state_d = S_STEP;
                    final_d = 1'b1;
                end else if (timer_q == interval_q - T_ONE) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                // Source advanced at the end of S_STEP.
                display_d = i_rand;
                if (final_q || step_cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_cnt_d = step_cnt_q + C_ONE;
                    interval_d = interval_q + BASE;
                    timer_d    = '0;
                    state_d    = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            interval_q <= '0;
            step_cnt_q <= '0;
            final_q    <= 1'b0;
            display_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            step_cnt_q <= step_cnt_d;
            final_q    <= final_d;
            display_q  <= display_d;
        end
    end

    // Pulses are decoded from the state register only.
    assign o_step    = (state_q == S_STEP);
    assign o_done    = (state_q == S_DONE);
    assign o_busy    = (state_q != S_IDLE);
    assign o_display = display_q;

`ifdef RNG_ROLL_HISTORY_EN
    logic [3:0] last_q, last_d;
    logic [3:0] prev_q, prev_d;

    always_comb begin
        last_d = last_q;
        prev_d = prev_q;
        if (state_q == S_DONE) begin
            prev_d = last_q;
            last_d = display_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 4'd0;
            prev_q <= 4'd0;
        end else begin
            last_q <= last_d;
            prev_q <= prev_d;
        end
    end

    assign o_prev = prev_q;
`else
    assign o_prev = 4'd0;
`endif

endmodule

// File: tb/tb_rng_roll_ctrl.sv
// tb_rng_roll_ctrl: directed and randomized rolls of rng_roll_ctrl
// against a cycle-level model built from step-time arithmetic.
module tb_rng_roll_ctrl;

    localparam int B = 4;
    localparam int N = 3;

    localparam int K_NONE  = 0;
    localparam int K_STOP  = 1;
    localparam int K_START = 2;
    localparam int K_BOTH  = 3;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic       i_stop;
    logic [3:0] i_rand;
    logic       o_step;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_display;
    logic [3:0] o_prev;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] disp_m = 4'd0;
    logic [3:0] last_m = 4'd0;
    logic [3:0] prev_m = 4'd0;
    logic [3:0] rand_log [0:255];
    int         steps [$];

    always #5 i_clk = ~i_clk;

    rng_roll_ctrl #(
        .BASE_INTERVAL(B),
        .NUM_STEPS(N),
        .TIMER_W(8)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_stop(i_stop),
        .i_rand(i_rand),
        .o_step(o_step),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_display(o_display),
        .o_prev(o_prev)
    );

    task automatic chk(input string tag, input int c,
                       input logic [3:0] got,
                       input logic [3:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h",
                   tag, c, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Cycle of step k in a roll started at cycle 0: (k+1)*B wait cycles
    // per step plus one step and one sample cycle for each earlier step.
    function automatic int step_at(input int k);
        return B * (k + 1) * (k + 2) / 2 + 2 * k + 1;
    endfunction

    function automatic bit in_steps(input int c);
        foreach (steps[i]) if (steps[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_wait(input int c);
        if (c < 1 || c >= step_at(N - 1)) return 1'b0;
        for (int k = 0; k < N; k++)
            if (c == step_at(k) || c == step_at(k) + 1)
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all(input int c, input logic s,
                             input logic b, input logic d);
        chk("step", c, {3'b0, o_step}, {3'b0, s});
        chk("busy", c, {3'b0, o_busy}, {3'b0, b});
        chk("done", c, {3'b0, o_done}, {3'b0, d});
        chk("display", c, o_display, disp_m);
        chk("prev", c, o_prev, prev_m);
    endtask

    // One roll starting in cycle 0, with an optional event at cycle ev.
    task automatic run_roll(input int kind, input int ev);
        int done_c;
        steps = {};
        for (int k = 0; k < N; k++) begin
            if (kind != K_NONE && step_at(k) >= ev) break;
            steps.push_back(step_at(k));
        end
        if (kind == K_STOP) begin
            steps.push_back(ev + 1);
            done_c = ev + 3;
        end else if (kind == K_START || kind == K_BOTH) begin
            for (int k = 0; k < N; k++)
                steps.push_back(ev + step_at(k));
            done_c = steps[$] + 2;
        end else begin
            done_c = steps[$] + 2;
        end
        i_start = 1'b1;
        i_stop  = 1'b0;
        i_rand  = 4'($urandom);
        rand_log[0] = i_rand;
        tick();
        for (int c = 1; c <= done_c + 3; c++) begin
            if (c >= 2 && in_steps(c - 2))
                disp_m = rand_log[c - 1];
`ifdef RNG_ROLL_HISTORY_EN
            if (c == done_c + 1) begin
                prev_m = last_m;
                last_m = disp_m;
            end
`endif
            check_all(c, in_steps(c), c <= done_c, c == done_c);
            i_start = (c == ev) &&
                      (kind == K_START || kind == K_BOTH);
            i_stop  = (c == ev) &&
                      (kind == K_STOP || kind == K_BOTH);
            i_rand  = 4'($urandom);
            rand_log[c] = i_rand;
            tick();
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    initial begin
        int ev;
        int kind;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_rand  = 4'd0;
        #2;
        check_all(0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        i_rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            i_rand = 4'($urandom);
            tick();
            check_all(c, 1'b0, 1'b0, 1'b0);
        end

        run_roll(K_NONE, 0);
        run_roll(K_STOP, 10);
        run_roll(K_START, 10);
        run_roll(K_BOTH, 10);
        run_roll(K_NONE, 0);
        run_roll(K_STOP, 2);

        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom_range(0, 3));
            do ev = int'($urandom_range(1, 30));
            while (!is_wait(ev));
            run_roll(kind, ev);
        end

        // Reset in the middle of a roll.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            i_rand = 4'($urandom);
            tick();
        end
        i_rst_n = 1'b0;
        disp_m  = 4'd0;
        last_m  = 4'd0;
        prev_m  = 4'd0;
        #1;
        check_all(8, 1'b0, 1'b0, 1'b0);
        tick();
        check_all(9, 1'b0, 1'b0, 1'b0);
        tick();
        i_rst_n = 1'b1;
        for (int c = 10; c < 50; c++) begin
            i_rand = 4'($urandom);
            check_all(c, 1'b0, 1'b0, 1'b0);
            tick();
        end

        run_roll(K_NONE, 0);
        run_roll(K_NONE, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_roll_ctrl.md
# rng_roll_ctrl

Roll sequencer for the Lab1 4-bit random-number datapath. On a start pulse it advances the random source with `o_step` pulses at progressively longer intervals, which gives a slowing "roulette" effect. After a fixed number of steps, or on an early stop request, it latches the final value for the seven-segment display. It sits between the debounced key inputs and the random generator/display path in the top level.

## Interface
Reset i_rst_n, asynchronous, active-low; clock i_clk.

Parameters:
- BASE_INTERVAL, 500_000: wait cycles before step 0; each later step waits BASE_INTERVAL more than the previous one.
- NUM_STEPS, 16: steps per uninterrupted roll (≥1).
- TIMER_W, 24: timer/interval width. NUM_STEPS*BASE_INTERVAL must fit in TIMER_W bits.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_start  in  1  single-cycle pulse, debounced upstream; starts or restarts a roll
- i_stop  in  1  single-cycle pulse; ends the current roll early
- i_rand  in  4  current value of the random source
- o_step  out  1  one-cycle advance pulse to the random source
- o_busy  out  1  high while a roll is in progress
- o_done  out  1  one-cycle pulse when the result is final
- o_display  out  4  last sampled value
- o_prev  out  4  previous completed result (HISTORY_EN only)

## Operation
- States: S_IDLE, S_WAIT, S_STEP, S_SAMPLE, S_DONE.
- Reset values:
  - state S_IDLE.
  - o_step, o_busy, o_done, o_display, o_prev all 0.
  - timer, interval, step_cnt, final flag all 0.
- S_IDLE:
  - i_start → S_WAIT with timer=0, interval=BASE_INTERVAL, step_cnt=0, final=0.
  - i_stop ignored.
- S_WAIT:
  - timer increments each cycle.
  - When timer==interval-1 → S_STEP.
  - i_start → restart: same register loads as from S_IDLE, stay in S_WAIT.
  - i_stop → S_STEP with final=1.
  - i_start and i_stop in the same cycle: i_start wins.
- S_STEP:
  - o_step=1 for this one cycle.
  - Next state S_SAMPLE.
  - Inputs ignored.
- S_SAMPLE:
  - o_display ← i_rand.
  - If final, or step_cnt==NUM_STEPS-1 → S_DONE.
  - Else step_cnt+1, interval+BASE_INTERVAL, timer=0 → S_WAIT.
  - Inputs ignored.
- S_DONE:
  - o_done=1 for this one cycle.
  - History update per Configuration.
  - Next state S_IDLE.
  - Inputs ignored.
- o_busy=1 in every state except S_IDLE.
- o_display holds its value in S_IDLE until the next S_SAMPLE.
- Arithmetic is unsigned, with no wrap permitted under the parameter constraint. step_cnt width is $clog2(NUM_STEPS)+1.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from input to output.
- If i_start is sampled at edge 0, S_WAIT occupies cycles 1..BASE_INTERVAL.
- Step k (0-based) follows (k+1)*BASE_INTERVAL wait cycles, then one S_STEP cycle and one S_SAMPLE cycle.
- Full roll: start edge to o_done = BASE_INTERVAL*NUM_STEPS*(NUM_STEPS+1)/2 + 2*NUM_STEPS + 1 cycles.
- Early stop sampled in cycle c of S_WAIT: S_STEP at c+1, S_SAMPLE at c+2, S_DONE at c+3.
- The random source sees o_step and updates at the end of the S_STEP cycle. i_rand is sampled in S_SAMPLE.
- Reset mid-roll: immediate return to S_IDLE with all outputs 0. No o_step is issued until a new i_start.

## Configuration
- Macro RNG_ROLL_HISTORY_EN.
- Defined:
  - Internal result register last_r (reset 0).
  - In S_DONE: o_prev ← last_r, last_r ← o_display.
  - So after two completed rolls, o_prev holds the first result.
- Undefined:
  - No last_r register.
  - o_prev is tied to 4'd0.
  - All other behaviour is identical.

## Test plan
All scenarios use BASE_INTERVAL=4, NUM_STEPS=3.
- Reset → o_step/o_busy/o_done/o_display/o_prev all 0; with no stimulus, they stay 0 for 50 cycles.
- Full roll: i_start at edge 0, i_rand=4'd9 → o_step at cycles 5, 15, 29; o_done at 31; o_display=9; o_busy high for cycles 1..31.
- Early stop: i_stop at cycle 10 → o_step at 5 and 11; o_done at 13; no further o_step.
- Restart and simultaneous inputs:
  - i_start again at cycle 10 → next o_step at 15, then 25, 39; o_done at 41.
  - i_start and i_stop together at cycle 10 give the same result.
- History (RNG_ROLL_HISTORY_EN): roll with i_rand=7, then roll with i_rand=3 → o_display=3, o_prev=7 after the second o_done. Without the macro, o_prev=0.
- i_rst_n low at cycle 8, released at 10 → all outputs 0; no o_step in the following 40 cycles.
